// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified serial transmitter, slave to an external sclk/lrclk pair.
// One sample pair is buffered in a holding register ahead of the frame being shifted out.
module i2s_tx_stereo #(
    parameter int DATA_W = 24,
    parameter int MODE   = 0
) (
    input  logic              i_sclk,
    input  logic              i_rst,
    input  logic              i_lrclk,
    input  logic [DATA_W-1:0] i_l_data,
    input  logic [DATA_W-1:0] i_r_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_sdout,
    output logic              o_underrun
);
    localparam int            CW       = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_DELAY, S_SHIFT} state_t;

    state_t            r_state, w_state_nx;
    logic              r_lr_q;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_l, r_hold_r;
    logic [DATA_W-1:0] r_frm_l, r_frm_r;
    logic [DATA_W-1:0] r_shreg, w_shreg_nx;
    logic [CW-1:0]     r_cnt, w_cnt_nx;
    logic              r_sdout, w_sdout_nx;
    logic              r_underrun;

    logic              w_edge, w_left, w_accept;
    logic [DATA_W-1:0] w_load_l, w_load_r, w_edge_word, w_frm_word;

    assign o_in_ready = !r_hold_full;
    assign o_sdout    = r_sdout;
    assign o_underrun = r_underrun;

    assign w_edge   = (r_state != S_SYNC) && (i_lrclk != r_lr_q);
    assign w_left   = w_edge && !i_lrclk;
    assign w_accept = i_in_valid && !r_hold_full;
    assign w_load_l = r_hold_full ? r_hold_l : '0;
    assign w_load_r = r_hold_full ? r_hold_r : '0;

    // Left-justified starts on the edge itself, before frm_l has been updated.
    assign w_edge_word = w_left ? w_load_l : r_frm_r;
    assign w_frm_word  = r_lr_q ? r_frm_r : r_frm_l;

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            r_lr_q      <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_frm_l     <= '0;
            r_frm_r     <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_lr_q     <= i_lrclk;
            r_underrun <= w_left && !r_hold_full;
            if (w_left) begin
                r_frm_l <= w_load_l;
                r_frm_r <= w_load_r;
            end
            // Accept and clear are exclusive: accept needs an empty buffer, clear a full one.
            if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold_l    <= i_l_data;
                r_hold_r    <= i_r_data;
            end else if (w_left) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_SYNC;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_sdout <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_shreg <= w_shreg_nx;
            r_cnt   <= w_cnt_nx;
            r_sdout <= w_sdout_nx;
        end
    end

    // An lrclk edge always restarts the slot, truncating whatever word was in flight.
    always_comb begin
        w_state_nx = r_state;
        w_sdout_nx = 1'b0;
        w_shreg_nx = r_shreg;
        w_cnt_nx   = r_cnt;
        if (w_edge) begin
            w_cnt_nx = LAST_CNT;
            if (MODE == 1) begin
                w_state_nx = S_SHIFT;
                w_sdout_nx = w_edge_word[DATA_W-1];
                w_shreg_nx = w_edge_word << 1;
            end else begin
                w_state_nx = S_DELAY;
            end
        end else begin
            case (r_state)
                S_SYNC: w_state_nx = S_IDLE;
                S_DELAY: begin
                    w_state_nx = S_SHIFT;
                    w_sdout_nx = w_frm_word[DATA_W-1];
                    w_shreg_nx = w_frm_word << 1;
                end
                S_SHIFT: begin
                    w_sdout_nx = r_shreg[DATA_W-1];
                    w_shreg_nx = r_shreg << 1;
                    w_cnt_nx   = r_cnt - ONE;
                    if (r_cnt == ONE) begin
                        w_state_nx = S_IDLE;
                    end
                end
                default: w_state_nx = r_state;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Bench for i2s_tx_stereo: drives one MODE=0 and one MODE=1 instance with the same
// sclk/lrclk stream and checks every bit against a slot-level timing model.
module tb_i2s_tx_stereo;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lr  = 1'b1;
    logic         v   = 1'b0;
    logic [W-1:0] ld  = '0;
    logic [W-1:0] rd  = '0;
    logic         rdy0, sd0, ur0, rdy1, sd1, ur1;

    i2s_tx_stereo #(.DATA_W(W), .MODE(0)) u_m0 (
        .i_sclk(clk), .i_rst(rst), .i_lrclk(lr), .i_l_data(ld), .i_r_data(rd),
        .i_in_valid(v), .o_in_ready(rdy0), .o_sdout(sd0), .o_underrun(ur0));

    i2s_tx_stereo #(.DATA_W(W), .MODE(1)) u_m1 (
        .i_sclk(clk), .i_rst(rst), .i_lrclk(lr), .i_l_data(ld), .i_r_data(rd),
        .i_in_valid(v), .o_in_ready(rdy1), .o_sdout(sd1), .o_underrun(ur1));

    always #5 clk = ~clk;

    typedef struct {
        int           slot;
        bit           give;
        logic [W-1:0] gl, gr;
        logic [W-1:0] el, er;
        bit           eur;
    } frame_t;

    frame_t tbl[9];

    int           n_vec = 0;
    int           n_bad = 0;
    int           pos = 0;
    int           k = 0;
    bit           have_edge = 1'b0;
    logic [W-1:0] w = '0;
    logic         lr_prev = 1'b0;
    bit           sync_pending = 1'b1;
    bit           m_full = 1'b0;
    logic [W-1:0] cur_l = '0, cur_r = '0;
    bit           cur_ur = 1'b0;
    logic [W-1:0] acc_l = '0, acc_r = '0;
    int           acc_cnt = 0;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at posedge %0d: got %b, expected %b", nm, pos, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at posedge %0d: got %0d, expected %0d", nm, pos, act, exp);
        end
    endtask

    // Called at a negedge: apply inputs, take one posedge, check at the next negedge.
    task automatic step(input logic lr_i, input logic v_i, input logic [W-1:0] l_i,
                        input logic [W-1:0] r_i);
        bit   is_edge, left, acc, exp_ur;
        logic e0, e1;
        int   d;
        lr = lr_i; v = v_i; ld = l_i; rd = r_i;
        is_edge = (lr_i != lr_prev) && !sync_pending;
        left    = is_edge && !lr_i;
        acc     = v_i && !m_full;
        if (v_i && rdy0) acc_cnt++;
        @(posedge clk);
        pos++;
        exp_ur = left && cur_ur;
        if (acc) begin
            m_full = 1'b1;
            acc_l  = l_i;
            acc_r  = r_i;
        end else if (left) begin
            m_full = 1'b0;
        end
        if (is_edge) begin
            have_edge = 1'b1;
            k = pos;
            w = lr_i ? cur_r : cur_l;
        end
        lr_prev = lr_i;
        sync_pending = 1'b0;
        @(negedge clk);
        d  = pos - k;
        e1 = (have_edge && d < W) ? w[W-1-d] : 1'b0;
        e0 = (have_edge && d >= 1 && d <= W) ? w[W-d] : 1'b0;
        chk("sdout_m0", sd0, e0);
        chk("sdout_m1", sd1, e1);
        chk("underrun_m0", ur0, exp_ur);
        chk("underrun_m1", ur1, exp_ur);
        chk("in_ready_m0", rdy0, !m_full);
        chk("in_ready_m1", rdy1, !m_full);
    endtask

    initial begin
        tbl[0] = '{32, 1'b1, 24'hA5A5A5, 24'h123456, 24'h000000, 24'h000000, 1'b1};
        tbl[1] = '{32, 1'b0, 24'h000000, 24'h000000, 24'hA5A5A5, 24'h123456, 1'b0};
        tbl[2] = '{32, 1'b1, 24'h7FFFFF, 24'h800001, 24'h000000, 24'h000000, 1'b1};
        tbl[3] = '{32, 1'b1, 24'hFFFFFF, 24'h000001, 24'h7FFFFF, 24'h800001, 1'b0};
        tbl[4] = '{16, 1'b1, 24'h8000FF, 24'hABCDEF, 24'hFFFFFF, 24'h000001, 1'b0};
        tbl[5] = '{16, 1'b1, 24'h13579B, 24'h2468AC, 24'h8000FF, 24'hABCDEF, 1'b0};
        tbl[6] = '{25, 1'b1, 24'hC3C3C3, 24'h3C3C3C, 24'h13579B, 24'h2468AC, 1'b0};
        tbl[7] = '{24, 1'b0, 24'h000000, 24'h000000, 24'hC3C3C3, 24'h3C3C3C, 1'b0};
        tbl[8] = '{32, 1'b0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1'b1};

        @(negedge clk);
        chk("reset_sdout_m0", sd0, 1'b0);
        chk("reset_sdout_m1", sd1, 1'b0);
        chk("reset_underrun_m0", ur0, 1'b0);
        chk("reset_underrun_m1", ur1, 1'b0);
        chk("reset_ready_m0", rdy0, 1'b1);
        chk("reset_ready_m1", rdy1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        // lrclk=1 against lr_q=0 on the SYNC cycle must not count as an edge.
        repeat (3) step(1'b1, 1'b0, '0, '0);

        for (int f = 0; f < 9; f++) begin
            cur_l = tbl[f].el; cur_r = tbl[f].er; cur_ur = tbl[f].eur;
            acc_cnt = 0;
            for (int c = 0; c < tbl[f].slot; c++) step(1'b0, 1'b0, '0, '0);
            for (int c = 0; c < tbl[f].slot; c++) begin
                if (tbl[f].give && c == 3) step(1'b1, 1'b1, tbl[f].gl, tbl[f].gr);
                else                       step(1'b1, 1'b0, '0, '0);
            end
            chk_int("table_accepts", acc_cnt, tbl[f].give ? 1 : 0);
        end

        // Back-pressure: valid held high with data changing every cycle.
        for (int b = 0; b < 3; b++) begin
            if (b == 0) begin cur_l = '0; cur_r = '0; cur_ur = 1'b1; end
            else        begin cur_l = acc_l; cur_r = acc_r; cur_ur = 1'b0; end
            acc_cnt = 0;
            for (int c = 0; c < 64; c++)
                step((c < 32) ? 1'b0 : 1'b1, 1'b1,
                     {12'hA00, 3'b011, 9'(pos)}, {12'h5C0, 3'b000, 9'(pos)});
            chk_int("bp_accepts", acc_cnt, 1);
        end

        // Reset while MODE=0 is driving bit 10 of a left word; a further pair sits in hold.
        cur_l = acc_l; cur_r = acc_r; cur_ur = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            if (c == 2) step(1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
            else        step(1'b0, 1'b0, '0, '0);
        end
        chk("pre_reset_bit10_m0", sd0, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_reset_sdout_m0", sd0, 1'b0);
        chk("mid_reset_sdout_m1", sd1, 1'b0);
        chk("mid_reset_ready_m0", rdy0, 1'b1);
        chk("mid_reset_ready_m1", rdy1, 1'b1);
        chk("mid_reset_underrun_m0", ur0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        have_edge = 1'b0; m_full = 1'b0; lr_prev = 1'b0; sync_pending = 1'b1;
        cur_l = '0; cur_r = '0; cur_ur = 1'b1;
        repeat (10) step(1'b0, 1'b0, '0, '0);
        repeat (32) step(1'b1, 1'b0, '0, '0);
        repeat (32) step(1'b0, 1'b0, '0, '0);
        repeat (32) step(1'b1, 1'b0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/i2s_tx_stereo.md
# i2s_tx_stereo

Parametrised stereo I2S serial transmitter, slave to an externally generated `sclk`/`lrclk` pair. It buffers one left/right sample pair through a valid/ready input and shifts each channel out MSB-first. It supports standard I2S (one-bit delay) and left-justified framing, and flags underruns. It sits between the effects datapath and the DAC pins, alongside the clock generator that drives `sclk`/`lrclk`.

## Interface
- `DATA_W`, 24: sample width in bits, range 8–32.
- `MODE`, 0: framing. 0 = I2S (MSB one `sclk` after the `lrclk` edge); 1 = left-justified (MSB on the edge).
- `sclk` input 1: bit clock; the only clock, all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `lrclk` input 1: word select; 0 = left, 1 = right; synchronous to `sclk`.
- `l_data` input DATA_W: left sample, two's complement.
- `r_data` input DATA_W: right sample.
- `in_valid` input 1: `l_data`/`r_data` are valid.
- `in_ready` output 1: holding register empty; transfer when `in_valid && in_ready` at a rising edge.
- `sdout` output 1: serial data, registered.
- `underrun` output 1: one-cycle pulse when a frame starts with no sample buffered.

## Operation
- Storage:
  - Holding pair `hold_l`/`hold_r` with a `hold_full` flag.
  - Frame pair `frm_l`/`frm_r`.
  - Shift register `DATA_W` wide.
  - Bit counter of width $clog2(DATA_W+1).
  - `lr_q`, the previous `lrclk`.
- `in_ready = !hold_full` (combinational from the flag).
- Edge detection: an edge occurs at the posedge where `lrclk != lr_q`. `lr_q <= lrclk` every cycle.
- States:
  - SYNC: after reset; captures `lr_q` only; goes to IDLE on the next posedge. No edge is detected in SYNC.
  - IDLE: `sdout <= 0`. On an edge: MODE=1 goes to SHIFT and drives the MSB this posedge; MODE=0 goes to DELAY.
  - DELAY: one cycle with `sdout <= 0`, then SHIFT driving the MSB.
  - SHIFT: drives the remaining bits MSB→LSB, one per posedge. After the LSB has been driven, goes to IDLE.
- An edge seen in DELAY or SHIFT truncates the current word. The new channel restarts exactly as from IDLE, and its remaining bits are discarded.
- Channel select:
  - Falling edge of `lrclk` (left start): load `frm_l`/`frm_r`, then shift `frm_l`.
  - Rising edge (right start): shift `frm_r`.
- Frame load at a left start:
  - If `hold_full`: `frm <= hold`, `hold_full <= 0`.
  - Otherwise: `frm <= 0` for both channels, and `underrun` pulses high for that one cycle.
  - The right channel of a frame always uses the value loaded at its left start.
- Simultaneous input and left start with `hold_full=0`: the incoming pair goes to the holding register (`hold_full <= 1`), the frame is zeros, and `underrun` fires.
- Input acceptance while `hold_full=1` is impossible, since `in_ready=0`.
- Bits beyond `DATA_W` in a slot: `sdout = 0`.

## Timing
- Reset values:
  - Outputs: `sdout=0`, `underrun=0`, `in_ready=1`.
  - Internal: state SYNC, `hold_full=0`, `frm_l=frm_r=0`, counter 0, `lr_q=0`.
- Edge at posedge k:
  - MODE=1: bit i of the word is driven at posedge k+(DATA_W-1-i).
  - MODE=0: bit i of the word is driven at posedge k+1+(DATA_W-1-i).
- Input-to-pin latency: a sample accepted before left-start posedge k has its MSB on `sdout` at k (MODE=1) or k+1 (MODE=0).
- `in_ready` rises the cycle after the left-start posedge that empties the holding register.
- Slot length is set by `lrclk`. Slots of DATA_W+MODE_DELAY sclks or more transmit complete words; shorter slots truncate.
- Reset asserted mid-word:
  - `sdout` drops to 0 immediately (asynchronously) and the buffered sample is discarded.
  - After release the block spends one cycle in SYNC; the first complete word follows the next detected edge.

## Test plan
- MODE=0, DATA_W=24, 64 sclk/frame, input pair L=0xA5A5A5, R=0x123456: sdout is 0 at the edge cycle, then 101001011010010110100101 on the left slot and 000100100011010001010110 on the right slot, with zeros for the remaining 7 bits of each slot.
- MODE=1, same stimulus: the MSB appears on the edge posedge, with no delay bit; 8 trailing zeros per slot.
- No `in_valid` before a left start: `underrun` is high for exactly one cycle at that posedge, and both slots transmit 24 zeros. Next, supply L=0x7FFFFF: it is transmitted in the following frame and `underrun` stays 0.
- Back-pressure: hold `in_valid=1` with changing data. Exactly one pair is accepted per frame, `in_ready` is 0 from acceptance until the next left start, and the transmitted samples equal the accepted ones in order.
- Short slots, 16 sclk/slot with DATA_W=24, MODE=0: each slot carries the top 15 bits, and the next channel's MSB starts on schedule after each edge.
- Reset at bit 10 of a left word: `sdout=0` immediately. After release, nothing is transmitted until the first edge following the SYNC cycle; the prior sample is not resent and `in_ready=1`.
